// File: rtl/counter_pkg.sv
// counter_pkg: shared modes, result record and next-state function for the up/down modulo counter
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Next count plus the event pulses it produces; 32-bit so any WIDTH up to 31 fits
    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        unf;
        logic        ld_err;
    } count_t;

    // Priority ld > (inc&dec) > inc > dec > hold; all compares against max_val, never all-ones
    function automatic count_t next_count(
        input logic [31:0] cur,
        input logic [31:0] din,
        input logic        ld,
        input logic        inc,
        input logic        dec,
        input logic [31:0] max_val,
        input logic        sat
    );
        count_t r;
        r = '{val: cur, ovf: 1'b0, unf: 1'b0, ld_err: 1'b0};
        if (ld) begin
            r.ld_err = din > max_val;
            r.val    = r.ld_err ? max_val : din;
        end else if (inc && !dec) begin
            r.ovf = cur == max_val;
            r.val = r.ovf ? (sat ? cur : 32'd0) : cur + 32'd1;
        end else if (dec && !inc) begin
            r.unf = cur == 32'd0;
            r.val = r.unf ? (sat ? cur : max_val) : cur - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_firewall.sv
// counter_firewall: simulation-only monitor that flags illegal counter states and requests
module counter_firewall #(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter bit STRICT  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    input logic             ld,
    input logic             inc,
    input logic             dec,
    input logic [WIDTH-1:0] data_in,
    input logic [WIDTH-1:0] data_out
);

    // Compare zero-extended so a full-range MAX_VAL does not turn these into constant compares
    localparam logic [31:0] MAX32 = 32'(MAX_VAL);

    // Screen every edge while out of reset; strict mode also rejects requests that would over/underflow
    always @(posedge clk) begin
        if (rst) begin
            assert (32'(data_out) <= MAX32)
                else $error("counter_firewall: data_out %0d above MAX_VAL %0d", data_out, MAX_VAL);
            assert (!(ld && 32'(data_in) > MAX32))
                else $error("counter_firewall: load value %0d above MAX_VAL %0d", data_in, MAX_VAL);
            if (STRICT) begin
                assert (!(inc && !dec && !ld && 32'(data_out) == MAX32))
                    else $error("counter_firewall: inc at MAX_VAL");
                assert (!(dec && !inc && !ld && data_out == '0))
                    else $error("counter_firewall: dec at zero");
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable up/down modulo counter with wrap/saturate modes and event pulses
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int MODE     = MODE_WRAP,
    parameter int RST_VAL  = 0,
    parameter bit STRICT   = 1'b0,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("updown_mod_counter: WIDTH %0d outside 1..31", WIDTH);
    end
    if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
        $error("updown_mod_counter: MAX_VAL %0d outside 1..2**WIDTH-1", MAX_VAL);
    end
    if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("updown_mod_counter: RST_VAL %0d outside 0..MAX_VAL", RST_VAL);
    end
    if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
        $error("updown_mod_counter: MODE %0d is neither wrap nor saturate", MODE);
    end

    count_t                nxt;
    logic [WIDTH-1:0]      data_nxt;
    logic [31-WIDTH:0]     unused_hi;

    // Evaluate the next count and event pulses from the current count and strobes
    always_comb nxt = next_count(32'(data_out), 32'(data_in), ld, inc, dec, 32'(MAX_VAL), MODE == MODE_SAT);

    assign {unused_hi, data_nxt} = nxt.val;
    assign at_max = data_out == MAX;
    assign at_min = data_out == '0;

    // Count register and one-cycle event pulses, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= WIDTH'(RST_VAL);
            ovf      <= 1'b0;
            unf      <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            data_out <= data_nxt;
            ovf      <= nxt.ovf;
            unf      <= nxt.unf;
            ld_err   <= nxt.ld_err;
        end
    end

    if (CHECK_EN) begin : g_firewall
        counter_firewall #(
            .WIDTH   (WIDTH),
            .MAX_VAL (MAX_VAL),
            .STRICT  (STRICT)
        ) u_firewall (
            .clk      (clk),
            .rst      (rst),
            .ld       (ld),
            .inc      (inc),
            .dec      (dec),
            .data_in  (data_in),
            .data_out (data_out)
        );
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: table-driven check of wrap/saturate/full-width counters on shared stimulus
module tb_updown_mod_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [2:0] data_in = 3'd0;

    logic [2:0] w5_q, s5_q, w7_q, r5_q;
    logic w5_max, w5_min, w5_ovf, w5_unf, w5_err;
    logic s5_max, s5_min, s5_ovf, s5_unf, s5_err;
    logic w7_max, w7_min, w7_ovf, w7_unf, w7_err;
    logic r5_max, r5_min, r5_ovf, r5_unf, r5_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(3), .MAX_VAL(5), .MODE(MODE_WRAP), .CHECK_EN(1'b0)) u_w5 (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
        .data_out(w5_q), .at_max(w5_max), .at_min(w5_min), .ovf(w5_ovf), .unf(w5_unf), .ld_err(w5_err));

    updown_mod_counter #(.WIDTH(3), .MAX_VAL(5), .MODE(MODE_SAT), .STRICT(1'b1), .CHECK_EN(1'b0)) u_s5 (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
        .data_out(s5_q), .at_max(s5_max), .at_min(s5_min), .ovf(s5_ovf), .unf(s5_unf), .ld_err(s5_err));

    updown_mod_counter #(.WIDTH(3), .MODE(MODE_WRAP)) u_w7 (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
        .data_out(w7_q), .at_max(w7_max), .at_min(w7_min), .ovf(w7_ovf), .unf(w7_unf), .ld_err(w7_err));

    updown_mod_counter #(.WIDTH(3), .MAX_VAL(5), .MODE(MODE_SAT), .RST_VAL(5), .CHECK_EN(1'b0)) u_r5 (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
        .data_out(r5_q), .at_max(r5_max), .at_min(r5_min), .ovf(r5_ovf), .unf(r5_unf), .ld_err(r5_err));

    typedef struct {
        logic       ld, inc, dec;
        logic [2:0] din;
        logic [2:0] w5, s5, w7;
        logic [2:0] fw5, fs5, fw7;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // flags packed as {ovf, unf, ld_err}: 4 = ovf, 2 = unf, 1 = ld_err
    task automatic add(input int l, input int i, input int d, input int din,
                       input int w5, input int s5, input int w7,
                       input int fw5, input int fs5, input int fw7);
        vec_t v;
        v.ld = l[0]; v.inc = i[0]; v.dec = d[0]; v.din = din[2:0];
        v.w5 = w5[2:0]; v.s5 = s5[2:0]; v.w7 = w7[2:0];
        v.fw5 = fw5[2:0]; v.fs5 = fs5[2:0]; v.fw7 = fw7[2:0];
        vecs.push_back(v);
    endtask

    task automatic drive(input logic l, input logic i, input logic d, input logic [2:0] din);
        @(negedge clk);
        ld = l; inc = i; dec = d; data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   ld inc dec din  w5 s5 w7  fw5 fs5 fw7
        add(1, 0, 0, 5,    5, 5, 5,  0, 0, 0);
        add(0, 1, 0, 0,    0, 5, 6,  4, 4, 0);
        add(0, 0, 1, 0,    5, 4, 5,  2, 0, 0);
        add(1, 0, 0, 0,    0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 0,    1, 1, 1,  0, 0, 0);
        add(0, 1, 0, 0,    2, 2, 2,  0, 0, 0);
        add(0, 1, 0, 0,    3, 3, 3,  0, 0, 0);
        add(0, 1, 0, 0,    4, 4, 4,  0, 0, 0);
        add(0, 1, 0, 0,    5, 5, 5,  0, 0, 0);
        add(0, 1, 0, 0,    0, 5, 6,  4, 4, 0);
        add(0, 1, 0, 0,    1, 5, 7,  0, 4, 0);
        add(0, 1, 0, 0,    2, 5, 0,  0, 4, 4);
        add(1, 0, 0, 0,    0, 0, 0,  0, 0, 0);
        add(0, 0, 1, 0,    5, 0, 7,  2, 2, 2);
        add(1, 0, 0, 7,    5, 5, 7,  1, 1, 0);
        add(1, 1, 0, 2,    2, 2, 2,  0, 0, 0);
        add(1, 0, 0, 3,    3, 3, 3,  0, 0, 0);
        add(0, 1, 1, 0,    3, 3, 3,  0, 0, 0);
        add(0, 0, 0, 0,    3, 3, 3,  0, 0, 0);
        add(0, 0, 1, 0,    2, 2, 2,  0, 0, 0);

        #1 rst = 1'b0;
        #1;
        chk("reset w5.q", w5_q, 3'd0);
        chk("reset w5.flags", {w5_ovf, w5_unf, w5_err}, 3'd0);
        chk("reset w5.at_min", {2'b0, w5_min}, 3'd1);
        chk("reset w5.at_max", {2'b0, w5_max}, 3'd0);
        chk("reset w7.q", w7_q, 3'd0);
        chk("reset r5.q", r5_q, 3'd5);
        chk("reset r5.at_max", {2'b0, r5_max}, 3'd1);
        chk("reset r5.at_min", {2'b0, r5_min}, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].ld, vecs[k].inc, vecs[k].dec, vecs[k].din);
            chk($sformatf("v%0d w5.q", k), w5_q, vecs[k].w5);
            chk($sformatf("v%0d w5.flags", k), {w5_ovf, w5_unf, w5_err}, vecs[k].fw5);
            chk($sformatf("v%0d w5.at_max", k), {2'b0, w5_max}, {2'b0, vecs[k].w5 == 3'd5});
            chk($sformatf("v%0d w5.at_min", k), {2'b0, w5_min}, {2'b0, vecs[k].w5 == 3'd0});
            chk($sformatf("v%0d s5.q", k), s5_q, vecs[k].s5);
            chk($sformatf("v%0d s5.flags", k), {s5_ovf, s5_unf, s5_err}, vecs[k].fs5);
            chk($sformatf("v%0d w7.q", k), w7_q, vecs[k].w7);
            chk($sformatf("v%0d w7.flags", k), {w7_ovf, w7_unf, w7_err}, vecs[k].fw7);
            chk($sformatf("v%0d w7.at_max", k), {2'b0, w7_max}, {2'b0, vecs[k].w7 == 3'd7});
        end

        drive(1'b1, 1'b0, 1'b0, 3'd4);
        chk("mid w5.q before reset", w5_q, 3'd4);
        drive(1'b1, 1'b0, 1'b0, 3'd7);
        chk("pre-reset s5.ld_err", {2'b0, s5_err}, 3'd1);
        #2 rst = 1'b0;
        #1;
        chk("async w5.q", w5_q, 3'd0);
        chk("async s5.q", s5_q, 3'd0);
        chk("async s5.flags", {s5_ovf, s5_unf, s5_err}, 3'd0);
        chk("async r5.q", r5_q, 3'd5);
        @(negedge clk);
        ld = 1'b0;
        rst = 1'b1;

        drive(1'b1, 1'b0, 1'b0, 3'd5);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        chk("strict s5 hold", s5_q, 3'd5);
        chk("strict s5.ovf", {2'b0, s5_ovf}, 3'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        chk("s5.ovf clears", {2'b0, s5_ovf}, 3'd0);
        chk("w5.ovf clears", {2'b0, w5_ovf}, 3'd0);
        chk("w5 hold after wrap", w5_q, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
